// File: rtl/input_cmd_gen_pkg.sv
// Shared constants for the command front-end: ASCII command bytes, button indices,
// debounce defaults and the UART byte decoder.
package input_cmd_gen_pkg;

    localparam int DB_TICKS_DEF = 1_000_000;
    localparam int DB_W_DEF     = 20;

    localparam int NUM_BTN = 5;
    localparam int BTN_L   = 0;
    localparam int BTN_R   = 1;
    localparam int BTN_U   = 2;
    localparam int BTN_D   = 3;
    localparam int BTN_C   = 4;

    localparam logic [7:0] CMD_L    = 8'h4C;
    localparam logic [7:0] CMD_L_LC = 8'h6C;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] CMD_R_LC = 8'h72;
    localparam logic [7:0] CMD_U    = 8'h55;
    localparam logic [7:0] CMD_U_LC = 8'h75;
    localparam logic [7:0] CMD_D    = 8'h44;
    localparam logic [7:0] CMD_D_LC = 8'h64;
    localparam logic [7:0] CMD_C    = 8'h43;
    localparam logic [7:0] CMD_C_LC = 8'h63;
    localparam logic [7:0] CMD_S    = 8'h53;
    localparam logic [7:0] CMD_S_LC = 8'h73;
    localparam logic [7:0] CMD_M    = 8'h4D;
    localparam logic [7:0] CMD_M_LC = 8'h6D;
    localparam logic [7:0] CMD_F    = 8'h46;
    localparam logic [7:0] CMD_F_LC = 8'h66;

    typedef enum logic [3:0] {
        RX_NONE,
        RX_LEFT,
        RX_RIGHT,
        RX_UP,
        RX_DOWN,
        RX_CLEAR,
        RX_RUNSTOP,
        RX_MODE,
        RX_FUNC,
        RX_ERR
    } rx_cmd_e;

    function automatic rx_cmd_e decode_byte(input logic [7:0] b);
        case (b)
            CMD_L, CMD_L_LC: return RX_LEFT;
            CMD_R, CMD_R_LC: return RX_RIGHT;
            CMD_U, CMD_U_LC: return RX_UP;
            CMD_D, CMD_D_LC: return RX_DOWN;
            CMD_C, CMD_C_LC: return RX_CLEAR;
            CMD_S, CMD_S_LC: return RX_RUNSTOP;
            CMD_M, CMD_M_LC: return RX_MODE;
            CMD_F, CMD_F_LC: return RX_FUNC;
            default:         return RX_ERR;
        endcase
    endfunction

endpackage

// File: rtl/input_cmd_gen_if.sv
// Command bus from the input front-end to the stopwatch/watch core.
interface input_cmd_gen_if;
    logic left_pulse;
    logic right_pulse;
    logic up_pulse;
    logic down_pulse;
    logic clear_pulse;
    logic runstop;
    logic mode;
    logic function_mode;
    logic rx_err;

    modport master (
        output left_pulse, right_pulse, up_pulse, down_pulse, clear_pulse,
        output runstop, mode, function_mode, rx_err
    );

    modport slave (
        input left_pulse, right_pulse, up_pulse, down_pulse, clear_pulse,
        input runstop, mode, function_mode, rx_err
    );
endinterface

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchroniser, stability counter, and a registered marker
// that is high for the cycle in which the debounced level has just risen.
module btn_debounce #(
    parameter int DB_TICKS = 1_000_000,
    parameter int DB_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam logic [DB_W-1:0] TC = DB_W'(DB_TICKS - 1);

    logic            sync_1, sync_2, level;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == TC) begin
                // Stable long enough: accept; only a 0->1 change marks an edge.
                level <= sync_2;
                cnt   <= '0;
                rise  <= sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/input_cmd_gen.sv
// Command front-end: merges debounced buttons and UART command bytes into one-cycle
// pulses plus runstop, display-mode and function-mode levels for the core.
module input_cmd_gen
    import input_cmd_gen_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF,
    parameter int DB_W     = DB_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_btn,
    input  logic            i_sw_mode,
    input  logic            i_sw_func,
    input  logic [7:0]      i_rx_data,
    input  logic            i_rx_done,
    input_cmd_gen_if.master cmd
);
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] fire;
    logic               rx_done_q;
    logic               mode_tgl;
    logic               func_tgl;
    logic               rs_toggle;
    rx_cmd_e            rx_cmd;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DB_TICKS (DB_TICKS),
            .DB_W     (DB_W)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .btn  (i_btn[i]),
            .rise (btn_rise[i])
        );
    end

    always_comb begin
        // A strobe held high for several cycles is still a single command.
        rx_cmd = (i_rx_done && !rx_done_q) ? decode_byte(i_rx_data) : RX_NONE;
        fire         = '0;
        fire[BTN_L]  = btn_rise[BTN_L] | (rx_cmd == RX_LEFT);
        fire[BTN_R]  = btn_rise[BTN_R] | (rx_cmd == RX_RIGHT);
        fire[BTN_U]  = btn_rise[BTN_U] | (rx_cmd == RX_UP);
        fire[BTN_D]  = btn_rise[BTN_D] | (rx_cmd == RX_DOWN);
        fire[BTN_C]  = btn_rise[BTN_C] | (rx_cmd == RX_CLEAR);
        // R doubles as start/stop only in stopwatch mode; both sources collapse to one toggle.
        rs_toggle    = (rx_cmd == RX_RUNSTOP) | (btn_rise[BTN_R] & ~cmd.function_mode);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_done_q       <= 1'b0;
            mode_tgl        <= 1'b0;
            func_tgl        <= 1'b0;
            cmd.left_pulse  <= 1'b0;
            cmd.right_pulse <= 1'b0;
            cmd.up_pulse    <= 1'b0;
            cmd.down_pulse  <= 1'b0;
            cmd.clear_pulse <= 1'b0;
            cmd.runstop     <= 1'b0;
            cmd.rx_err      <= 1'b0;
        end else begin
            rx_done_q       <= i_rx_done;
            mode_tgl        <= mode_tgl ^ (rx_cmd == RX_MODE);
            func_tgl        <= func_tgl ^ (rx_cmd == RX_FUNC);
            cmd.left_pulse  <= fire[BTN_L];
            cmd.right_pulse <= fire[BTN_R];
            cmd.up_pulse    <= fire[BTN_U];
            cmd.down_pulse  <= fire[BTN_D];
            cmd.clear_pulse <= fire[BTN_C];
            cmd.runstop     <= cmd.runstop ^ rs_toggle;
            cmd.rx_err      <= (rx_cmd == RX_ERR);
        end
    end

    assign cmd.mode          = i_sw_mode ^ mode_tgl;
    assign cmd.function_mode = i_sw_func ^ func_tgl;
endmodule

// File: tb/tb_input_cmd_gen.sv
// Directed and random stimulus for input_cmd_gen, checked every cycle against a
// behavioural model of the debounce rule and the command byte table.
module tb_input_cmd_gen;
    localparam int DB_T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btn = '0;
    logic       sw_mode = 1'b0;
    logic       sw_func = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;

    input_cmd_gen_if cmd ();

    input_cmd_gen #(.DB_TICKS(DB_T), .DB_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_btn     (btn),
        .i_sw_mode (sw_mode),
        .i_sw_func (sw_func),
        .i_rx_data (rx_data),
        .i_rx_done (rx_done),
        .cmd       (cmd)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: raw samples seen by the synchroniser, accepted levels, run lengths.
    bit [4:0] m_s1, m_s2, m_lvl, m_pend;
    int       m_run [5];
    bit       m_rx_prev, m_rs, m_mt, m_ft;
    bit [4:0] e_pulse;
    bit       e_err;
    int       n_pulse [5];
    int       n_err;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lc(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
    endfunction

    task automatic model_edge();
        logic [7:0] ch;
        bit         got, us, um, uf;
        bit [4:0]   ucmd, new_pend;
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0;
            for (int b = 0; b < 5; b++) m_run[b] = 0;
            m_rx_prev = 0; m_rs = 0; m_mt = 0; m_ft = 0;
            e_pulse = '0; e_err = 0;
            return;
        end
        got  = rx_done && !m_rx_prev;
        ch   = lc(rx_data);
        ucmd = '0; us = 0; um = 0; uf = 0; e_err = 0;
        if (got) begin
            case (ch)
                8'h6C: ucmd[0] = 1;
                8'h72: ucmd[1] = 1;
                8'h75: ucmd[2] = 1;
                8'h64: ucmd[3] = 1;
                8'h63: ucmd[4] = 1;
                8'h73: us = 1;
                8'h6D: um = 1;
                8'h66: uf = 1;
                default: e_err = 1;
            endcase
        end
        e_pulse = m_pend | ucmd;
        if (us || (m_pend[1] && !(sw_func ^ m_ft))) m_rs = !m_rs;
        m_mt ^= um;
        m_ft ^= uf;
        m_rx_prev = rx_done;
        new_pend = '0;
        for (int b = 0; b < 5; b++) begin
            if (m_s2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB_T) begin
                    m_lvl[b]    = m_s2[b];
                    m_run[b]    = 0;
                    new_pend[b] = m_s2[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_s2   = m_s1;
        m_s1   = btn;
        m_pend = new_pend;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("left_pulse",    cmd.left_pulse,    e_pulse[0]);
            chk("right_pulse",   cmd.right_pulse,   e_pulse[1]);
            chk("up_pulse",      cmd.up_pulse,      e_pulse[2]);
            chk("down_pulse",    cmd.down_pulse,    e_pulse[3]);
            chk("clear_pulse",   cmd.clear_pulse,   e_pulse[4]);
            chk("rx_err",        cmd.rx_err,        e_err);
            chk("runstop",       cmd.runstop,       m_rs);
            chk("mode",          cmd.mode,          sw_mode ^ m_mt);
            chk("function_mode", cmd.function_mode, sw_func ^ m_ft);
            n_pulse[0] += int'(cmd.left_pulse);
            n_pulse[1] += int'(cmd.right_pulse);
            n_pulse[2] += int'(cmd.up_pulse);
            n_pulse[3] += int'(cmd.down_pulse);
            n_pulse[4] += int'(cmd.clear_pulse);
            n_err      += int'(cmd.rx_err);
        end
    endtask

    task automatic clr_counts();
        for (int b = 0; b < 5; b++) n_pulse[b] = 0;
        n_err = 0;
    endtask

    task automatic send(input logic [7:0] b, input int width);
        rx_data = b;
        rx_done = 1'b1;
        tick(width);
        rx_done = 1'b0;
        tick(1);
    endtask

    task automatic press(input int idx, input int hold);
        btn[idx] = 1'b1;
        tick(hold);
        btn[idx] = 1'b0;
        tick(10);
    endtask

    logic [7:0] letters [16] = '{8'h4C, 8'h6C, 8'h52, 8'h72, 8'h55, 8'h75, 8'h44, 8'h64,
                                 8'h43, 8'h63, 8'h53, 8'h73, 8'h4D, 8'h6D, 8'h46, 8'h66};

    initial begin
        // Reset held with every input active; outputs stay low through and after.
        btn = 5'h1F; rx_done = 1'b1; rx_data = 8'h6C;
        tick(4);
        rst = 1'b1; rx_done = 1'b0; btn = '0;
        tick(1);
        chk("rst_runstop", cmd.runstop, 1'b0);
        tick(8);

        // Held button: exactly one pulse; short glitch: none.
        clr_counts();
        press(2, 20);
        chk("up_hold_one_pulse", n_pulse[2] == 1, 1'b1);
        clr_counts();
        press(2, 2);
        chk("up_glitch_no_pulse", n_pulse[2] == 0, 1'b1);

        // UART: held strobe decodes once; unknown byte flags an error only.
        clr_counts();
        send(8'h6C, 3);
        chk("uart_l_one_pulse", n_pulse[0] == 1, 1'b1);
        clr_counts();
        send(8'h58, 1);
        chk("uart_x_err", n_err == 1, 1'b1);
        chk("uart_x_no_cmd", (n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3] + n_pulse[4]) == 0, 1'b1);

        // Runstop via R in stopwatch mode, not in watch mode; 's' toggles back.
        clr_counts();
        press(1, 8);
        chk("r_sw_runstop", cmd.runstop, 1'b1);
        chk("r_sw_pulse", n_pulse[1] == 1, 1'b1);
        send(8'h46, 1);
        chk("f_func_mode", cmd.function_mode, 1'b1);
        clr_counts();
        press(1, 8);
        chk("r_watch_runstop", cmd.runstop, 1'b1);
        chk("r_watch_pulse", n_pulse[1] == 1, 1'b1);
        send(8'h73, 2);
        chk("s_runstop", cmd.runstop, 1'b0);
        send(8'h66, 1);

        // Collision: debounced U edge and 'u' land on the same clock edge.
        clr_counts();
        btn[2] = 1'b1;
        tick(6);
        rx_data = 8'h75; rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0; btn[2] = 1'b0;
        tick(10);
        chk("collide_up_single", n_pulse[2] == 1, 1'b1);

        // Collision: R edge in stopwatch mode and 'S' on the same edge toggle once.
        btn[1] = 1'b1;
        tick(6);
        rx_data = 8'h53; rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0; btn[1] = 1'b0;
        tick(10);
        chk("collide_rs_once", cmd.runstop, 1'b1);

        // Mode toggles and reset restoring the switch level.
        sw_mode = 1'b1;
        tick(1);
        send(8'h4D, 1);
        chk("m_mode0", cmd.mode, 1'b0);
        send(8'h6D, 1);
        chk("m_mode1", cmd.mode, 1'b1);
        send(8'h4D, 1);
        rst = 1'b0;
        tick(2);
        chk("rst_mode_sw", cmd.mode, sw_mode);
        rst = 1'b1;
        tick(2);

        // Random phase against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                int idx;
                idx = $urandom_range(0, 4);
                btn[idx] = ~btn[idx];
            end
            if (rx_done) begin
                if ($urandom_range(0, 1) == 0) rx_done = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                rx_done = 1'b1;
                rx_data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : letters[$urandom_range(0, 15)];
            end
            if ($urandom_range(0, 199) == 0) sw_mode = ~sw_mode;
            if ($urandom_range(0, 199) == 0) sw_func = ~sw_func;
            rst = ($urandom_range(0, 499) != 0);
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
